// File: rtl/axi_lite_master_if.sv
// Bundle of the user command/response port and the AXI4-Lite master channels.
// Ports: cmd_* (command in), rsp_* (response out), M_AXI_AW/W/B/AR/R channels.
// Modports: master (the axi_lite_master side), slave (user + AXI slave side).
interface axi_lite_master_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) ();
  // user command port
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_wr;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_wstrb;
  // user response port (no backpressure)
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic [1:0]              rsp_resp;
  logic                    rsp_timeout;
  // AXI4-Lite write address / data / response
  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]              M_AXI_AWPROT;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;
  // AXI4-Lite read address / data
  logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]              M_AXI_ARPROT;
  logic                    M_AXI_ARVALID;
  logic                    M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]              M_AXI_RRESP;
  logic                    M_AXI_RVALID;
  logic                    M_AXI_RREADY;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one user command into one AXI
// read or write and returns one response pulse (or a timeout abort).
// Latency: AXI valids 1 cycle after accept; rsp_valid 1 cycle after final B/R handshake.
// Backpressure: cmd_ready only in IDLE; response port has none.
// Ports: M_AXI_ACLK, M_AXI_ARESETN (async, active-low), bus (master modport).
module axi_lite_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_TIMEOUT_CYCLES   = 256
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  axi_lite_master_if.master     bus
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
  localparam int CNT_W  = ($clog2(C_TIMEOUT_CYCLES + 1) > 9) ? $clog2(C_TIMEOUT_CYCLES + 1) : 9;
  // counter value at which the next edge makes the count reach the limit
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(C_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;

  state_t                         state, state_d;
  logic                           cmd_ready_q, cmd_ready_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]              wstrb_q, wstrb_d;
  logic                           awvalid_q, awvalid_d;
  logic                           wvalid_q, wvalid_d;
  logic                           bready_q, bready_d;
  logic                           arvalid_q, arvalid_d;
  logic                           rready_q, rready_d;
  logic                           aw_done_q, aw_done_d;
  logic                           w_done_q, w_done_d;
  logic                           rsp_valid_q, rsp_valid_d;
  logic                           rsp_timeout_q, rsp_timeout_d;
  logic [1:0]                     rsp_resp_q, rsp_resp_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]               tmo_cnt_q, tmo_cnt_d;

  logic accept, tmo_hit, aw_fire, w_fire;

  assign accept  = cmd_ready_q & bus.cmd_valid;
  // >= rather than == so a phase entered at the limit still aborts promptly
  assign tmo_hit = (state != IDLE) && (tmo_cnt_q >= TMO_LAST);
  assign aw_fire = awvalid_q & bus.M_AXI_AWREADY;
  assign w_fire  = wvalid_q & bus.M_AXI_WREADY;

  always_comb begin
    state_d       = state;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_resp_d    = rsp_resp_q;
    rsp_rdata_d   = rsp_rdata_q;
    tmo_cnt_d     = (state != IDLE) ? tmo_cnt_q + 1'b1 : tmo_cnt_q;

    case (state)
      IDLE: begin
        if (accept) begin
          addr_d    = bus.cmd_addr;
          wdata_d   = bus.cmd_wdata;
          wstrb_d   = bus.cmd_wstrb;
          tmo_cnt_d = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (bus.cmd_wr) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // either channel may complete now or may have completed earlier
        if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      WRESP: begin
        if (bready_q && bus.M_AXI_BVALID) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = bus.M_AXI_BRESP;
          state_d     = IDLE;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      RADDR: begin
        if (arvalid_q && bus.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      RDATA: begin
        if (rready_q && bus.M_AXI_RVALID) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus.M_AXI_RDATA;
          rsp_resp_d  = bus.M_AXI_RRESP;
          state_d     = IDLE;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort: the only way back to IDLE without a response already flagged.
    if ((state != IDLE) && (state_d == IDLE) && !rsp_valid_d) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_resp_d    = 2'b10;
    end

    // Registered so it rises on the first edge after reset and coincides with rsp_valid.
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      cmd_ready_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_resp_q    <= 2'b00;
      rsp_rdata_q   <= '0;
      tmo_cnt_q     <= '0;
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_rdata_q   <= rsp_rdata_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_resp      = rsp_resp_q;
  assign bus.rsp_timeout   = rsp_timeout_q;
  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = wstrb_q;
  assign bus.M_AXI_WVALID  = wvalid_q;
  assign bus.M_AXI_BREADY  = bready_q;
  assign bus.M_AXI_ARADDR  = addr_q;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_ARVALID = arvalid_q;
  assign bus.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: slave behaviour is scripted per test,
// expected responses go into a queue and a negedge monitor checks each rsp_valid.
module tb_axi_lite_master;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   rsp_seen = 0;
  exp_t exp_q[$];

  axi_lite_master_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  axi_lite_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(4),
    .C_TIMEOUT_CYCLES(16)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESETN(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic [1:0] resp, input logic tmo);
    exp_t e;
    e.rdata = rdata;
    e.resp  = resp;
    e.tmo   = tmo;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command right after an edge and let it be accepted on the next edge.
  task automatic cmd_go(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_wstrb = strb;
    @(negedge clk);
    chk("cmd_ready_before_accept", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Response monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid === 1'b1) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_resp", {30'd0, bus.rsp_resp}, {30'd0, e.resp});
        chk("rsp_timeout", bus.rsp_timeout, e.tmo);
        chk("cmd_ready_with_rsp", bus.cmd_ready, 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid     = 1'b0;
    bus.cmd_wr        = 1'b0;
    bus.cmd_addr      = 4'h0;
    bus.cmd_wdata     = 32'h0;
    bus.cmd_wstrb     = 4'h0;
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BRESP   = 2'b00;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RDATA   = 32'h0BAD_0BAD;
    bus.M_AXI_RRESP   = 2'b00;
    bus.M_AXI_RVALID  = 1'b0;

    // ---- reset state
    #12;
    chk("rst_awvalid", bus.M_AXI_AWVALID, 0);
    chk("rst_wvalid", bus.M_AXI_WVALID, 0);
    chk("rst_bready", bus.M_AXI_BREADY, 0);
    chk("rst_arvalid", bus.M_AXI_ARVALID, 0);
    chk("rst_rready", bus.M_AXI_RREADY, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    @(posedge clk);
    #7 rst_n = 1'b1;
    #1 chk("cmd_ready_before_first_edge", bus.cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready_after_first_edge", bus.cmd_ready, 1);

    // ---- write, AW and W ready together, B one cycle later
    push_exp(32'h0, 2'b00, 1'b0);
    cmd_go(1'b1, 4'h4, 32'h0000_0003, 4'hF);
    bus.M_AXI_AWREADY = 1'b1;
    bus.M_AXI_WREADY  = 1'b1;
    @(negedge clk);
    chk("t1_awvalid", bus.M_AXI_AWVALID, 1);
    chk("t1_wvalid", bus.M_AXI_WVALID, 1);
    chk("t1_awaddr", bus.M_AXI_AWADDR, 32'h4);
    chk("t1_wdata", bus.M_AXI_WDATA, 32'h3);
    chk("t1_wstrb", bus.M_AXI_WSTRB, 32'hF);
    chk("t1_awprot", bus.M_AXI_AWPROT, 0);
    chk("t1_cmd_ready_busy", bus.cmd_ready, 0);
    tick();
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BVALID  = 1'b1;
    bus.M_AXI_BRESP   = 2'b00;
    @(negedge clk);
    chk("t1_awvalid_drop", bus.M_AXI_AWVALID, 0);
    chk("t1_wvalid_drop", bus.M_AXI_WVALID, 0);
    chk("t1_bready", bus.M_AXI_BREADY, 1);
    tick();
    bus.M_AXI_BVALID = 1'b0;
    @(negedge clk);
    chk("t1_bready_drop", bus.M_AXI_BREADY, 0);
    tick();
    @(negedge clk);
    chk("t1_rsp_one_cycle", bus.rsp_valid, 0);

    // ---- read of 0x8, R data after two wait cycles
    push_exp(32'hDEAD_BEEF, 2'b00, 1'b0);
    cmd_go(1'b0, 4'h8, 32'h0, 4'h0);
    bus.M_AXI_ARREADY = 1'b1;
    @(negedge clk);
    chk("t3_arvalid", bus.M_AXI_ARVALID, 1);
    chk("t3_araddr", bus.M_AXI_ARADDR, 32'h8);
    chk("t3_rready_early", bus.M_AXI_RREADY, 0);
    tick();
    bus.M_AXI_ARREADY = 1'b0;
    @(negedge clk);
    chk("t3_arvalid_drop", bus.M_AXI_ARVALID, 0);
    chk("t3_rready", bus.M_AXI_RREADY, 1);
    tick();
    tick();
    bus.M_AXI_RVALID = 1'b1;
    bus.M_AXI_RDATA  = 32'hDEAD_BEEF;
    bus.M_AXI_RRESP  = 2'b00;
    tick();
    bus.M_AXI_RVALID = 1'b0;
    bus.M_AXI_RDATA  = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("t3_rsp_valid", bus.rsp_valid, 1);
    chk("t3_rready_drop", bus.M_AXI_RREADY, 0);

    // ---- write, WREADY three cycles after AWREADY; rdata must hold
    push_exp(32'hDEAD_BEEF, 2'b00, 1'b0);
    cmd_go(1'b1, 4'hC, 32'h1234_5678, 4'h3);
    bus.M_AXI_AWREADY = 1'b1;
    tick();
    bus.M_AXI_AWREADY = 1'b0;
    @(negedge clk);
    chk("t2_awvalid_drop", bus.M_AXI_AWVALID, 0);
    chk("t2_wvalid_held1", bus.M_AXI_WVALID, 1);
    chk("t2_bready_wait1", bus.M_AXI_BREADY, 0);
    tick();
    @(negedge clk);
    chk("t2_wvalid_held2", bus.M_AXI_WVALID, 1);
    tick();
    bus.M_AXI_WREADY = 1'b1;
    @(negedge clk);
    chk("t2_wvalid_held3", bus.M_AXI_WVALID, 1);
    chk("t2_bready_wait3", bus.M_AXI_BREADY, 0);
    chk("t2_wstrb", bus.M_AXI_WSTRB, 32'h3);
    tick();
    bus.M_AXI_WREADY = 1'b0;
    bus.M_AXI_BVALID = 1'b1;
    @(negedge clk);
    chk("t2_wvalid_drop", bus.M_AXI_WVALID, 0);
    chk("t2_bready", bus.M_AXI_BREADY, 1);
    tick();
    bus.M_AXI_BVALID = 1'b0;
    tick();

    // ---- read with no ARREADY: abort after 16 cycles
    push_exp(32'hDEAD_BEEF, 2'b10, 1'b1);
    cmd_go(1'b0, 4'h2, 32'h0, 4'h0);
    @(negedge clk);
    chk("t4_arvalid_start", bus.M_AXI_ARVALID, 1);
    for (int i = 1; i <= 15; i++) tick();
    @(negedge clk);
    chk("t4_arvalid_before_limit", bus.M_AXI_ARVALID, 1);
    chk("t4_no_rsp_before_limit", bus.rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("t4_arvalid_drop", bus.M_AXI_ARVALID, 0);
    chk("t4_rsp_valid", bus.rsp_valid, 1);
    tick();
    @(negedge clk);
    chk("t4_timeout_one_cycle", bus.rsp_timeout, 0);

    // ---- reset while in WRESP, then a normal read
    cmd_go(1'b1, 4'h5, 32'h5555_AAAA, 4'hF);
    bus.M_AXI_AWREADY = 1'b1;
    bus.M_AXI_WREADY  = 1'b1;
    tick();
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    @(negedge clk);
    chk("t5_bready_before_reset", bus.M_AXI_BREADY, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_bready_reset", bus.M_AXI_BREADY, 0);
    chk("t5_awaddr_reset", bus.M_AXI_AWADDR, 0);
    chk("t5_wdata_reset", bus.M_AXI_WDATA, 0);
    chk("t5_rsp_rdata_reset", bus.rsp_rdata, 0);
    chk("t5_cmd_ready_reset", bus.cmd_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    push_exp(32'hA5A5_5A5A, 2'b00, 1'b0);
    cmd_go(1'b0, 4'h4, 32'h0, 4'h0);
    bus.M_AXI_ARREADY = 1'b1;
    tick();
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RVALID  = 1'b1;
    bus.M_AXI_RDATA   = 32'hA5A5_5A5A;
    tick();
    bus.M_AXI_RVALID = 1'b0;
    bus.M_AXI_RDATA  = 32'h0BAD_0BAD;
    tick();

    // ---- back-to-back with cmd_valid held: write then read
    push_exp(32'hA5A5_5A5A, 2'b10, 1'b0);
    push_exp(32'h1111_2222, 2'b11, 1'b0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = 4'h1;
    bus.cmd_wdata = 32'hCAFE_F00D;
    bus.cmd_wstrb = 4'h1;
    @(negedge clk);
    chk("t6_cmd_ready_first", bus.cmd_ready, 1);
    tick();
    bus.cmd_wr        = 1'b0;
    bus.cmd_addr      = 4'h6;
    bus.M_AXI_AWREADY = 1'b1;
    bus.M_AXI_WREADY  = 1'b1;
    @(negedge clk);
    chk("t6_cmd_ready_busy", bus.cmd_ready, 0);
    chk("t6_awaddr_stable", bus.M_AXI_AWADDR, 32'h1);
    chk("t6_wdata", bus.M_AXI_WDATA, 32'hCAFE_F00D);
    tick();
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BVALID  = 1'b1;
    bus.M_AXI_BRESP   = 2'b10;
    @(negedge clk);
    chk("t6_cmd_ready_wresp", bus.cmd_ready, 0);
    chk("t6_no_ar_in_wresp", bus.M_AXI_ARVALID, 0);
    tick();
    bus.M_AXI_BVALID = 1'b0;
    @(negedge clk);
    chk("t6_first_rsp", bus.rsp_valid, 1);
    chk("t6_no_ar_in_rsp_cycle", bus.M_AXI_ARVALID, 0);
    tick();
    bus.cmd_valid     = 1'b0;
    bus.M_AXI_ARREADY = 1'b1;
    @(negedge clk);
    chk("t6_second_arvalid", bus.M_AXI_ARVALID, 1);
    chk("t6_second_araddr", bus.M_AXI_ARADDR, 32'h6);
    tick();
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RVALID  = 1'b1;
    bus.M_AXI_RDATA   = 32'h1111_2222;
    bus.M_AXI_RRESP   = 2'b11;
    tick();
    bus.M_AXI_RVALID = 1'b0;
    bus.M_AXI_RDATA  = 32'h0BAD_0BAD;
    bus.M_AXI_RRESP  = 2'b00;

    repeat (4) tick();
    chk("rsp_queue_drained", exp_q.size(), 0);
    chk("rsp_count", rsp_seen, 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
